// File: rtl/fetch_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_redirect_ctrl_pkg
// Brief   : Shared PC type, widths and fetch-control state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_redirect_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] pc_t;

  localparam pc_t RESET_PC = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : fetch_redirect_ctrl_sat_counter
// Brief   : Saturating up-counter with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fetch_redirect_ctrl
// Brief   : Fetch stall/flush sequencing and redirect PC arbitration.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard_stall_req,
  input  logic                  mem_stall_req,
  input  logic                  ex_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] ex_redirect_pc,
  output logic                  fetch_stall,
  output logic                  fetch_flush,
  output logic                  decode_flush,
  output logic [ADDR_WIDTH-1:0] irreg_pc,
  output logic                  redirect_pending,
  output logic [PERF_WIDTH-1:0] perf_stall_cycles,
  output logic [PERF_WIDTH-1:0] perf_redirects
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_DRAIN_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  fetch_ctrl_state_e r_state;
  pc_t               r_pending_pc;
  logic              r_pending;
  logic [CNT_W-1:0]  r_cnt;

  logic w_apply;
  logic w_latch;

  // Redirect application overrides every stall source in the same cycle.
  always_comb begin
    fetch_stall  = 1'b0;
    fetch_flush  = 1'b0;
    decode_flush = 1'b0;
    irreg_pc     = '0;
    w_apply      = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      HOLD: begin
        if (mem_stall_req) begin
          fetch_stall = 1'b1;
        end else begin
          w_apply  = 1'b1;
          irreg_pc = r_pending_pc;
        end
      end
      DRAIN: begin
        if (ex_redirect_valid && !mem_stall_req) begin
          w_apply  = 1'b1;
          irreg_pc = ex_redirect_pc;
        end else if (ex_redirect_valid) begin
          w_latch     = 1'b1;
          fetch_stall = 1'b1;
          fetch_flush = 1'b1;
        end else begin
          fetch_flush = 1'b1;
          fetch_stall = mem_stall_req;
        end
      end
      default: begin
        if (ex_redirect_valid && !mem_stall_req) begin
          w_apply  = 1'b1;
          irreg_pc = ex_redirect_pc;
        end else if (ex_redirect_valid) begin
          w_latch     = 1'b1;
          fetch_stall = 1'b1;
        end else begin
          fetch_stall = hazard_stall_req | mem_stall_req;
        end
      end
    endcase
    if (w_apply) begin
      fetch_flush  = 1'b1;
      decode_flush = 1'b1;
      fetch_stall  = 1'b0;
    end
  end

  // Pending is gated by the live stall so it drops in the replay cycle itself.
  assign redirect_pending = r_pending & mem_stall_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_pending_pc <= RESET_PC;
      r_pending    <= 1'b0;
      r_cnt        <= '0;
    end else if (w_apply) begin
      r_pending <= 1'b0;
      if (FLUSH_CYCLES > 1) begin
        r_state <= DRAIN;
        r_cnt   <= c_DRAIN_LOAD;
      end else begin
        r_state <= RUN;
      end
    end else if (w_latch) begin
      r_pending_pc <= ex_redirect_pc;
      r_pending    <= 1'b1;
      r_state      <= HOLD;
    end else if ((r_state == DRAIN) && !mem_stall_req) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt <= c_CNT_ONE) begin
        r_state <= RUN;
      end
    end
  end

  fetch_redirect_ctrl_sat_counter #(
    .WIDTH (PERF_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_stall),
    .clear (1'b0),
    .count (perf_stall_cycles)
  );

  fetch_redirect_ctrl_sat_counter #(
    .WIDTH (PERF_WIDTH)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_apply),
    .clear (1'b0),
    .count (perf_redirects)
  );

endmodule
`default_nettype wire
